// File: rtl/mcu_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// opcode constants, ALU operation codes, datapath mux encodings and the
// bundled control-word struct that the output decoder hands to the top.
package mcu_pkg;

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_R     = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [2:0] ALU_RTYPE = 3'b111;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_AND   = 3'b110;
  localparam logic [2:0] ALU_LUI   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic       iOrD;
    logic       irWrite;
    logic       pcWrite;
    logic       pcWriteCondEq;
    logic       pcWriteCondNe;
    logic [1:0] pcSource;
    logic [2:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       regWrite;
    logic [1:0] regDst;
    logic [1:0] memToReg;
  } ctrl_t;

  // True for every opcode the datapath knows how to sequence.
  function automatic logic isKnownOpcode(input logic [5:0] op);
    case (op)
      OP_R, OP_ADDI, OP_ORI, OP_ANDI, OP_LUI, OP_LW, OP_SW,
      OP_BEQ, OP_BNE, OP_J, OP_JAL: isKnownOpcode = 1'b1;
      default:                      isKnownOpcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcu_output_decode.sv
// Moore output decoder for the multicycle control unit. Maps the current
// state (plus the latched opcode) onto the datapath control word. The only
// input-dependent outputs are ir_write/pc_write in FETCH, which follow
// mem_ready so the IR and PC load exactly when the fetch completes.
import mcu_pkg::*;

module mcu_output_decode (
  input  state_t      i_state,
  input  logic [5:0]  i_opcode,
  input  logic        i_memReady,
  output ctrl_t       o_ctrl
);

  // Decode the control word; everything not driven for a state stays 0.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.memRead  = 1'b1;
        o_ctrl.iOrD     = 1'b0;
        o_ctrl.aluSrcA  = 1'b0;
        o_ctrl.aluSrcB  = SRCB_FOUR;
        o_ctrl.aluOp    = ALU_ADD;
        o_ctrl.pcSource = PCSRC_ALU;
        o_ctrl.irWrite  = i_memReady;
        o_ctrl.pcWrite  = i_memReady;
      end
      S_DECODE: begin
        o_ctrl.aluSrcA = 1'b0;
        o_ctrl.aluSrcB = SRCB_IMM_SH2;
        o_ctrl.aluOp   = ALU_ADD;
      end
      S_EXEC_R: begin
        o_ctrl.aluSrcA = 1'b1;
        o_ctrl.aluSrcB = SRCB_REGB;
        o_ctrl.aluOp   = ALU_RTYPE;
      end
      S_WB_R: begin
        o_ctrl.regWrite = 1'b1;
        o_ctrl.regDst   = REGDST_RD;
        o_ctrl.memToReg = M2R_ALUOUT;
      end
      S_EXEC_I: begin
        o_ctrl.aluSrcA = 1'b1;
        o_ctrl.aluSrcB = SRCB_IMM;
        case (i_opcode)
          OP_ORI:  o_ctrl.aluOp = ALU_OR;
          OP_ANDI: o_ctrl.aluOp = ALU_AND;
          OP_LUI:  o_ctrl.aluOp = ALU_LUI;
          default: o_ctrl.aluOp = ALU_ADD;
        endcase
      end
      S_WB_I: begin
        o_ctrl.regWrite = 1'b1;
        o_ctrl.regDst   = REGDST_RT;
        o_ctrl.memToReg = M2R_ALUOUT;
      end
      S_MEM_ADDR: begin
        o_ctrl.aluSrcA = 1'b1;
        o_ctrl.aluSrcB = SRCB_IMM;
        o_ctrl.aluOp   = ALU_ADD;
      end
      S_MEM_RD: begin
        o_ctrl.memRead = 1'b1;
        o_ctrl.iOrD    = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.regWrite = 1'b1;
        o_ctrl.regDst   = REGDST_RT;
        o_ctrl.memToReg = M2R_MDR;
      end
      S_MEM_WR: begin
        o_ctrl.memWrite = 1'b1;
        o_ctrl.iOrD     = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.aluSrcA       = 1'b1;
        o_ctrl.aluSrcB       = SRCB_REGB;
        o_ctrl.aluOp         = ALU_SUB;
        o_ctrl.pcSource      = PCSRC_ALUOUT;
        o_ctrl.pcWriteCondEq = (i_opcode == OP_BEQ);
        o_ctrl.pcWriteCondNe = (i_opcode == OP_BNE);
      end
      S_JUMP: begin
        o_ctrl.pcWrite  = 1'b1;
        o_ctrl.pcSource = PCSRC_JUMP;
        if (i_opcode == OP_JAL) begin
          o_ctrl.regWrite = 1'b1;
          o_ctrl.regDst   = REGDST_RA;
          o_ctrl.memToReg = M2R_PC;
        end
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main sequencing FSM for the multicycle MIPS datapath. Holds the state
// register, the post-reset INIT counter and the next-state logic; the
// control word itself comes from mcu_output_decode.
// Optional macro MCU_ILLEGAL_TRAP_EN: unknown opcodes trap into TRAP and
// raise the sticky illegal_op flag. Without it they retire as a NOP.
import mcu_pkg::*;

module multicycle_control_unit #(
  parameter int unsigned INIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond_eq,
  output logic       pc_write_cond_ne,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [3:0] state_o,
  output logic       illegal_op
);

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_initCnt;
  ctrl_t      w_ctrl;

  // State register; reset aborts any access in flight by returning to INIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_INIT;
    else        r_state <= w_nextState;
  end

  // Count cycles spent in INIT so FETCH starts INIT_CYCLES after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  r_initCnt <= '0;
    else if (r_state != S_INIT)  r_initCnt <= '0;
    else if (r_initCnt != INIT_LAST) r_initCnt <= r_initCnt + 4'd1;
  end

  // Next-state sequencing, including opcode dispatch out of DECODE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_INIT:     if (r_initCnt == INIT_LAST) w_nextState = S_FETCH;
      S_FETCH:    if (mem_ready) w_nextState = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:                            w_nextState = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: w_nextState = S_EXEC_I;
          OP_LW, OP_SW:                    w_nextState = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                  w_nextState = S_BRANCH;
          OP_J, OP_JAL:                    w_nextState = S_JUMP;
`ifdef MCU_ILLEGAL_TRAP_EN
          default:                         w_nextState = S_TRAP;
`else
          default:                         w_nextState = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R:   w_nextState = S_WB_R;
      S_WB_R:     w_nextState = S_FETCH;
      S_EXEC_I:   w_nextState = S_WB_I;
      S_WB_I:     w_nextState = S_FETCH;
      S_MEM_ADDR: w_nextState = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) w_nextState = S_MEM_WB;
      S_MEM_WB:   w_nextState = S_FETCH;
      S_MEM_WR:   if (mem_ready) w_nextState = S_FETCH;
      S_BRANCH:   w_nextState = S_FETCH;
      S_JUMP:     w_nextState = S_FETCH;
      S_TRAP:     w_nextState = S_TRAP;
      default:    w_nextState = S_INIT;
    endcase
  end

`ifdef MCU_ILLEGAL_TRAP_EN
  logic r_illegal;

  // Sticky flag raised when DECODE sees an opcode outside the supported set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_illegal <= 1'b0;
    else if (r_state == S_DECODE && !isKnownOpcode(opcode))
      r_illegal <= 1'b1;
  end

  assign illegal_op = r_illegal;
`else
  assign illegal_op = 1'b0;
`endif

  mcu_output_decode u_outputDecode (
    .i_state    (r_state),
    .i_opcode   (opcode),
    .i_memReady (mem_ready),
    .o_ctrl     (w_ctrl)
  );

  assign mem_read         = w_ctrl.memRead;
  assign mem_write        = w_ctrl.memWrite;
  assign i_or_d           = w_ctrl.iOrD;
  assign ir_write         = w_ctrl.irWrite;
  assign pc_write         = w_ctrl.pcWrite;
  assign pc_write_cond_eq = w_ctrl.pcWriteCondEq;
  assign pc_write_cond_ne = w_ctrl.pcWriteCondNe;
  assign pc_source        = w_ctrl.pcSource;
  assign alu_op           = w_ctrl.aluOp;
  assign alu_src_a        = w_ctrl.aluSrcA;
  assign alu_src_b        = w_ctrl.aluSrcB;
  assign reg_write        = w_ctrl.regWrite;
  assign reg_dst          = w_ctrl.regDst;
  assign mem_to_reg       = w_ctrl.memToReg;
  assign state_o          = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit (INIT_CYCLES = 3).
// Each step drives the inputs just after a rising edge, pushes the control
// word expected for that cycle onto a scoreboard queue, then pops and
// compares it against the DUT outputs shortly afterwards.
// Honors MCU_ILLEGAL_TRAP_EN for the illegal-opcode expectations.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [3:0] state;
    logic       memRead;
    logic       memWrite;
    logic       iOrD;
    logic       irWrite;
    logic       pcWrite;
    logic       condEq;
    logic       condNe;
    logic [1:0] pcSource;
    logic [2:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       regWrite;
    logic [1:0] regDst;
    logic [1:0] memToReg;
    logic       illegal;
  } exp_t;

  typedef struct {
    string tag;
    exp_t  v;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic       pc_write_cond_eq, pc_write_cond_ne;
  logic [1:0] pc_source;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [3:0] state_o;
  logic       illegal_op;

  exp_t obsBits;
  sb_t  sbQ[$];
  int   errors = 0;
  int   checks = 0;

  multicycle_control_unit #(.INIT_CYCLES(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .opcode           (opcode),
    .mem_ready        (mem_ready),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .i_or_d           (i_or_d),
    .ir_write         (ir_write),
    .pc_write         (pc_write),
    .pc_write_cond_eq (pc_write_cond_eq),
    .pc_write_cond_ne (pc_write_cond_ne),
    .pc_source        (pc_source),
    .alu_op           (alu_op),
    .alu_src_a        (alu_src_a),
    .alu_src_b        (alu_src_b),
    .reg_write        (reg_write),
    .reg_dst          (reg_dst),
    .mem_to_reg       (mem_to_reg),
    .state_o          (state_o),
    .illegal_op       (illegal_op)
  );

  always #5 clk = ~clk;

  assign obsBits = {state_o, mem_read, mem_write, i_or_d, ir_write, pc_write,
                    pc_write_cond_eq, pc_write_cond_ne, pc_source, alu_op,
                    alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg,
                    illegal_op};

  function automatic exp_t mk(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.state = st;
    return e;
  endfunction

  function automatic exp_t fetchExp(input logic rdy);
    exp_t e;
    e = mk(4'd1);
    e.memRead  = 1'b1;
    e.aluSrcB  = 2'b01;
    e.aluOp    = 3'b100;
    e.irWrite  = rdy;
    e.pcWrite  = rdy;
    return e;
  endfunction

  function automatic exp_t decodeExp();
    exp_t e;
    e = mk(4'd2);
    e.aluSrcB = 2'b11;
    e.aluOp   = 3'b100;
    return e;
  endfunction

  task automatic applyStimulus(input logic rstN, input logic [5:0] opc, input logic rdy);
    @(posedge clk);
    #1;
    reset     = rstN;
    opcode    = opc;
    mem_ready = rdy;
  endtask

  task automatic pushExpected(input string tag, input exp_t e);
    sb_t item;
    item.tag = tag;
    item.v   = e;
    sbQ.push_back(item);
  endtask

  task automatic checkOutput();
    sb_t item;
    #1;
    item = sbQ.pop_front();
    checks++;
    assert (obsBits === item.v) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", item.tag, obsBits, item.v);
    end
  endtask

  task automatic step(input string tag, input logic rstN, input logic [5:0] opc,
                      input logic rdy, input exp_t e);
    applyStimulus(rstN, opc, rdy);
    pushExpected(tag, e);
    checkOutput();
  endtask

  initial begin
    exp_t e;

    // Reset, then three INIT cycles before the first fetch.
    step("rst",   1'b0, 6'h00, 1'b1, mk(4'd0));
    step("init0", 1'b1, 6'h00, 1'b1, mk(4'd0));
    step("init1", 1'b1, 6'h00, 1'b1, mk(4'd0));
    step("init2", 1'b1, 6'h00, 1'b1, mk(4'd0));

    // R-type with one fetch wait cycle.
    step("fetchWaitR", 1'b1, 6'b000000, 1'b0, fetchExp(1'b0));
    step("fetchR",     1'b1, 6'b000000, 1'b1, fetchExp(1'b1));
    step("decodeR",    1'b1, 6'b000000, 1'b1, decodeExp());
    e = mk(4'd3); e.aluSrcA = 1'b1; e.aluSrcB = 2'b00; e.aluOp = 3'b111;
    step("execR", 1'b1, 6'b000000, 1'b0, e);
    e = mk(4'd5); e.regWrite = 1'b1; e.regDst = 2'b01;
    step("wbR", 1'b1, 6'b000000, 1'b1, e);

    // LW with two memory wait cycles in MEM_RD.
    step("fetchLw",  1'b1, 6'b100011, 1'b1, fetchExp(1'b1));
    step("decodeLw", 1'b1, 6'b100011, 1'b0, decodeExp());
    e = mk(4'd7); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluOp = 3'b100;
    step("memAddrLw", 1'b1, 6'b100011, 1'b0, e);
    e = mk(4'd8); e.memRead = 1'b1; e.iOrD = 1'b1;
    step("memRdWait0", 1'b1, 6'b100011, 1'b0, e);
    step("memRdWait1", 1'b1, 6'b100011, 1'b0, e);
    step("memRdDone",  1'b1, 6'b100011, 1'b1, e);
    e = mk(4'd9); e.regWrite = 1'b1; e.regDst = 2'b00; e.memToReg = 2'b01;
    step("memWb", 1'b1, 6'b100011, 1'b1, e);

    // ORI: I-type with the OR ALU code.
    step("fetchOri",  1'b1, 6'b001101, 1'b1, fetchExp(1'b1));
    step("decodeOri", 1'b1, 6'b001101, 1'b0, decodeExp());
    e = mk(4'd4); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluOp = 3'b101;
    step("execOri", 1'b1, 6'b001101, 1'b0, e);
    e = mk(4'd6); e.regWrite = 1'b1; e.regDst = 2'b00;
    step("wbOri", 1'b1, 6'b001101, 1'b0, e);

    // LUI: I-type with the LUI ALU code.
    step("fetchLui",  1'b1, 6'b001111, 1'b1, fetchExp(1'b1));
    step("decodeLui", 1'b1, 6'b001111, 1'b0, decodeExp());
    e = mk(4'd4); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluOp = 3'b000;
    step("execLui", 1'b1, 6'b001111, 1'b0, e);
    e = mk(4'd6); e.regWrite = 1'b1;
    step("wbLui", 1'b1, 6'b001111, 1'b0, e);

    // BNE then BEQ.
    step("fetchBne",  1'b1, 6'b000101, 1'b1, fetchExp(1'b1));
    step("decodeBne", 1'b1, 6'b000101, 1'b0, decodeExp());
    e = mk(4'd11); e.aluSrcA = 1'b1; e.aluOp = 3'b001; e.pcSource = 2'b01; e.condNe = 1'b1;
    step("branchBne", 1'b1, 6'b000101, 1'b1, e);
    step("fetchBeq",  1'b1, 6'b000100, 1'b1, fetchExp(1'b1));
    step("decodeBeq", 1'b1, 6'b000100, 1'b0, decodeExp());
    e = mk(4'd11); e.aluSrcA = 1'b1; e.aluOp = 3'b001; e.pcSource = 2'b01; e.condEq = 1'b1;
    step("branchBeq", 1'b1, 6'b000100, 1'b0, e);

    // JAL then J.
    step("fetchJal",  1'b1, 6'b000011, 1'b1, fetchExp(1'b1));
    step("decodeJal", 1'b1, 6'b000011, 1'b0, decodeExp());
    e = mk(4'd12); e.pcWrite = 1'b1; e.pcSource = 2'b10;
    e.regWrite = 1'b1; e.regDst = 2'b10; e.memToReg = 2'b10;
    step("jumpJal", 1'b1, 6'b000011, 1'b0, e);
    step("fetchJ",  1'b1, 6'b000010, 1'b1, fetchExp(1'b1));
    step("decodeJ", 1'b1, 6'b000010, 1'b0, decodeExp());
    e = mk(4'd12); e.pcWrite = 1'b1; e.pcSource = 2'b10;
    step("jumpJ", 1'b1, 6'b000010, 1'b0, e);

    // SW completing after one wait cycle.
    step("fetchSw",  1'b1, 6'b101011, 1'b1, fetchExp(1'b1));
    step("decodeSw", 1'b1, 6'b101011, 1'b0, decodeExp());
    e = mk(4'd7); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluOp = 3'b100;
    step("memAddrSw", 1'b1, 6'b101011, 1'b0, e);
    e = mk(4'd10); e.memWrite = 1'b1; e.iOrD = 1'b1;
    step("memWrWait", 1'b1, 6'b101011, 1'b0, e);
    step("memWrDone", 1'b1, 6'b101011, 1'b1, e);

    // SW aborted by reset mid-write.
    step("fetchSw2",  1'b1, 6'b101011, 1'b1, fetchExp(1'b1));
    step("decodeSw2", 1'b1, 6'b101011, 1'b0, decodeExp());
    e = mk(4'd7); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluOp = 3'b100;
    step("memAddrSw2", 1'b1, 6'b101011, 1'b0, e);
    e = mk(4'd10); e.memWrite = 1'b1; e.iOrD = 1'b1;
    step("memWrBusy", 1'b1, 6'b101011, 1'b0, e);
    #1 reset = 1'b0;
    pushExpected("rstMidWr", mk(4'd0));
    checkOutput();
    step("rstHold",   1'b0, 6'b101011, 1'b1, mk(4'd0));
    step("reinit0",   1'b1, 6'b000000, 1'b0, mk(4'd0));
    step("reinit1",   1'b1, 6'b000000, 1'b0, mk(4'd0));
    step("reinit2",   1'b1, 6'b000000, 1'b0, mk(4'd0));

    // Unknown opcode 111111.
    step("fetchIll",  1'b1, 6'b111111, 1'b1, fetchExp(1'b1));
    step("decodeIll", 1'b1, 6'b111111, 1'b0, decodeExp());
`ifdef MCU_ILLEGAL_TRAP_EN
    e = mk(4'd13); e.illegal = 1'b1;
    step("trap0", 1'b1, 6'b000000, 1'b1, e);
    step("trap1", 1'b1, 6'b000000, 1'b1, e);
    step("trapRst", 1'b0, 6'b000000, 1'b1, mk(4'd0));
`else
    step("nopFetch", 1'b1, 6'b000000, 1'b0, fetchExp(1'b0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
